// File: rtl/mux_nto1_tdm_if.sv
// rtl/mux_nto1_tdm_if.sv - lane-side inputs and serial-side outputs of the N:1 TDM mux
interface mux_nto1_tdm_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    localparam int LW = $clog2(LANES);

    logic                   sync_in;
    logic [LANES*WIDTH-1:0] data_in;
    logic [LANES-1:0]       valid_in;
    logic [WIDTH-1:0]       data_out;
    logic                   valid_out;
    logic [LW-1:0]          lane_out;
    logic                   frame_start;

    modport master (
        output sync_in, data_in, valid_in,
        input  data_out, valid_out, lane_out, frame_start
    );

    modport slave (
        input  sync_in, data_in, valid_in,
        output data_out, valid_out, lane_out, frame_start
    );
endinterface

// File: rtl/mux_nto1_tdm.sv
// rtl/mux_nto1_tdm.sv - N-lane to 1-lane time-division multiplexer with optional packing
module mux_nto1_tdm #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int PACK  = 0,
    parameter int LW    = $clog2(LANES)
) (
    input logic           clk_4f,
    input logic           reset,
    mux_nto1_tdm_if.slave bus
);
    logic [LW-1:0]          cnt;
    logic [LANES*WIDTH-1:0] sh_data;
    logic [LANES-1:0]       sh_valid;
    logic [WIDTH-1:0]       data_q;
    logic                   valid_q;
    logic [LW-1:0]          lane_q;
    logic                   fs_q;

    logic                   cap;
    logic [WIDTH-1:0]       nxt_data;
    logic                   nxt_valid;
    logic [LW-1:0]          nxt_lane;
    logic [LW:0]            seen;
    logic                   found;

    assign cap = (cnt == LW'(LANES-1)) | bus.sync_in;

    // Slot selection from the shadow frame; packing walks set bits from lane 0 upward.
    always_comb begin
        nxt_data  = '0;
        nxt_valid = 1'b0;
        nxt_lane  = '0;
        seen      = '0;
        found     = 1'b0;
        if (PACK == 0) begin
            nxt_valid = sh_valid[cnt];
            nxt_lane  = cnt;
            if (sh_valid[cnt])
                nxt_data = sh_data[int'(cnt)*WIDTH +: WIDTH];
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (sh_valid[i] && !found) begin
                    if (seen == {1'b0, cnt}) begin
                        found    = 1'b1;
                        nxt_lane = LW'(i);
                        nxt_data = sh_data[i*WIDTH +: WIDTH];
                    end
                    seen = seen + 1'b1;
                end
            end
            nxt_valid = found;
        end
    end

    // Reset parks the counter on the last slot so the first edge captures a fresh frame.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            cnt      <= LW'(LANES-1);
            sh_data  <= '0;
            sh_valid <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            lane_q   <= '0;
            fs_q     <= 1'b0;
        end else begin
            if (cap) begin
                sh_data  <= bus.data_in;
                sh_valid <= bus.valid_in;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            data_q  <= nxt_data;
            valid_q <= nxt_valid;
            lane_q  <= nxt_lane;
            fs_q    <= (cnt == '0);
        end
    end

    assign bus.data_out    = data_q;
    assign bus.valid_out   = valid_q;
    assign bus.lane_out    = lane_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_mux_nto1_tdm.sv
// tb/tb_mux_nto1_tdm.sv - scoreboard bench for mux_nto1_tdm (PACK=0, PACK=1, 8x16)
module tb_mux_nto1_tdm;
    typedef struct packed {
        logic [15:0] data;
        logic        valid;
        logic [2:0]  lane;
        logic        fs;
    } slot_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    slot_t sb[$];

    always #5 clk = ~clk;

    mux_nto1_tdm_if #(.WIDTH(8),  .LANES(4)) if_a ();
    mux_nto1_tdm_if #(.WIDTH(8),  .LANES(4)) if_b ();
    mux_nto1_tdm_if #(.WIDTH(16), .LANES(8)) if_c ();

    mux_nto1_tdm #(.WIDTH(8),  .LANES(4), .PACK(0)) dut_a (.clk_4f(clk), .reset(rst_a), .bus(if_a.slave));
    mux_nto1_tdm #(.WIDTH(8),  .LANES(4), .PACK(1)) dut_b (.clk_4f(clk), .reset(rst_b), .bus(if_b.slave));
    mux_nto1_tdm #(.WIDTH(16), .LANES(8), .PACK(0)) dut_c (.clk_4f(clk), .reset(rst_c), .bus(if_c.slave));

    function automatic slot_t mk(input logic [15:0] d, input logic v, input int l, input logic f);
        slot_t s;
        s.data = d; s.valid = v; s.lane = 3'(l); s.fs = f;
        return s;
    endfunction

    function automatic slot_t get_a();
        return mk(16'(if_a.data_out), if_a.valid_out, int'(if_a.lane_out), if_a.frame_start);
    endfunction

    function automatic slot_t get_b();
        return mk(16'(if_b.data_out), if_b.valid_out, int'(if_b.lane_out), if_b.frame_start);
    endfunction

    function automatic slot_t get_c();
        return mk(if_c.data_out, if_c.valid_out, int'(if_c.lane_out), if_c.frame_start);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        slot_t act, exp;
        if_a.sync_in = 1'b0; if_a.data_in = 32'h1234_5678; if_a.valid_in = 4'b1111;
        rst_a = 1'b0;
        repeat (3) tick();
        #2 rst_a = 1'b1;
        #1 act = get_a();
        n_cmp++;
        if (act !== slot_t'(0)) begin
            n_bad++;
            $display("FAIL reset_async: got d=%h v=%b l=%0d fs=%b, want all 0", act.data, act.valid, act.lane, act.fs);
        end
        tick();
        if_a.data_in = 32'hDDCC_BBAA; if_a.valid_in = 4'b1111;
        rst_a = 1'b0;
        sb.push_back(mk(16'h00, 0, 3, 0));
        sb.push_back(mk(16'hAA, 1, 0, 1));
        sb.push_back(mk(16'hBB, 1, 1, 0));
        sb.push_back(mk(16'hCC, 1, 2, 0));
        sb.push_back(mk(16'hDD, 1, 3, 0));
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = sb.pop_front();
            act = get_a();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL cold_start slot %0d: got d=%h v=%b l=%0d fs=%b, want d=%h v=%b l=%0d fs=%b",
                         i, act.data, act.valid, act.lane, act.fs, exp.data, exp.valid, exp.lane, exp.fs);
            end
        end
    endtask

    task automatic test_pack0_partial();
        slot_t act, exp;
        rst_a = 1'b1;
        tick();
        if_a.sync_in = 1'b0; if_a.data_in = 32'hDDCC_BBAA; if_a.valid_in = 4'b0101;
        rst_a = 1'b0;
        sb.push_back(mk(16'h00, 0, 3, 0));
        sb.push_back(mk(16'hAA, 1, 0, 1));
        sb.push_back(mk(16'h00, 0, 1, 0));
        sb.push_back(mk(16'hCC, 1, 2, 0));
        sb.push_back(mk(16'h00, 0, 3, 0));
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = sb.pop_front();
            act = get_a();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL pack0_partial slot %0d: got d=%h v=%b l=%0d fs=%b, want d=%h v=%b l=%0d fs=%b",
                         i, act.data, act.valid, act.lane, act.fs, exp.data, exp.valid, exp.lane, exp.fs);
            end
        end
    endtask

    task automatic test_pack1();
        slot_t act, exp;
        if_b.sync_in = 1'b0; if_b.data_in = 32'hDDCC_BBAA; if_b.valid_in = 4'b1010;
        rst_b = 1'b0;
        sb.push_back(mk(16'h00, 0, 0, 0));
        sb.push_back(mk(16'hBB, 1, 1, 1));
        sb.push_back(mk(16'hDD, 1, 3, 0));
        sb.push_back(mk(16'h00, 0, 0, 0));
        sb.push_back(mk(16'h00, 0, 0, 0));
        sb.push_back(mk(16'hBB, 1, 1, 1));
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = sb.pop_front();
            act = get_b();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL pack1 slot %0d: got d=%h v=%b l=%0d fs=%b, want d=%h v=%b l=%0d fs=%b",
                         i, act.data, act.valid, act.lane, act.fs, exp.data, exp.valid, exp.lane, exp.fs);
            end
        end
    endtask

    task automatic test_back_to_back();
        slot_t act, exp;
        rst_a = 1'b1;
        tick();
        if_a.sync_in = 1'b0; if_a.data_in = 32'h4433_2211; if_a.valid_in = 4'b1111;
        rst_a = 1'b0;
        sb.push_back(mk(16'h00, 0, 3, 0));
        for (int j = 0; j < 8; j++)
            sb.push_back(mk(16'(8'h11 * (j + 1)), 1, j % 4, (j % 4) == 0));
        for (int i = 0; i < 9; i++) begin
            tick();
            exp = sb.pop_front();
            act = get_a();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL back_to_back slot %0d: got d=%h v=%b l=%0d fs=%b, want d=%h v=%b l=%0d fs=%b",
                         i, act.data, act.valid, act.lane, act.fs, exp.data, exp.valid, exp.lane, exp.fs);
            end
            if (i == 0) if_a.data_in = 32'h8877_6655;
        end
    endtask

    task automatic test_sync_mid();
        slot_t act, exp;
        rst_a = 1'b1;
        tick();
        if_a.sync_in = 1'b0; if_a.data_in = 32'hDDCC_BBAA; if_a.valid_in = 4'b1111;
        rst_a = 1'b0;
        sb.push_back(mk(16'h00, 0, 3, 0));
        sb.push_back(mk(16'hAA, 1, 0, 1));
        sb.push_back(mk(16'hBB, 1, 1, 0));
        sb.push_back(mk(16'h0C, 1, 0, 1));
        sb.push_back(mk(16'h0D, 1, 1, 0));
        sb.push_back(mk(16'h0E, 1, 2, 0));
        sb.push_back(mk(16'h0F, 1, 3, 0));
        for (int i = 0; i < 7; i++) begin
            tick();
            exp = sb.pop_front();
            act = get_a();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL sync_mid slot %0d: got d=%h v=%b l=%0d fs=%b, want d=%h v=%b l=%0d fs=%b",
                         i, act.data, act.valid, act.lane, act.fs, exp.data, exp.valid, exp.lane, exp.fs);
            end
            if (i == 1) begin
                if_a.sync_in = 1'b1;
                if_a.data_in = 32'h0F0E_0D0C;
            end else begin
                if_a.sync_in = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_8x16();
        slot_t act, exp;
        if_c.sync_in = 1'b0; if_c.valid_in = 8'hFF;
        for (int i = 0; i < 8; i++) if_c.data_in[i*16 +: 16] = 16'hA000 | 16'(i);
        rst_c = 1'b0;
        sb.push_back(mk(16'h0000, 0, 7, 0));
        for (int j = 0; j < 4; j++) sb.push_back(mk(16'hA000 | 16'(j), 1, j, j == 0));
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = sb.pop_front();
            act = get_c();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL c_first slot %0d: got d=%h v=%b l=%0d fs=%b, want d=%h v=%b l=%0d fs=%b",
                         i, act.data, act.valid, act.lane, act.fs, exp.data, exp.valid, exp.lane, exp.fs);
            end
        end
        #2 rst_c = 1'b1;
        #1 act = get_c();
        n_cmp++;
        if (act !== slot_t'(0)) begin
            n_bad++;
            $display("FAIL c_reset_mid: got d=%h v=%b l=%0d fs=%b, want all 0", act.data, act.valid, act.lane, act.fs);
        end
        for (int i = 0; i < 8; i++) if_c.data_in[i*16 +: 16] = 16'hB000 | 16'(i);
        tick();
        rst_c = 1'b0;
        sb.push_back(mk(16'h0000, 0, 7, 0));
        for (int j = 0; j < 8; j++) sb.push_back(mk(16'hB000 | 16'(j), 1, j, j == 0));
        for (int i = 0; i < 9; i++) begin
            tick();
            exp = sb.pop_front();
            act = get_c();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL c_restart slot %0d: got d=%h v=%b l=%0d fs=%b, want d=%h v=%b l=%0d fs=%b",
                         i, act.data, act.valid, act.lane, act.fs, exp.data, exp.valid, exp.lane, exp.fs);
            end
        end
    endtask

    initial begin
        if_a.sync_in = 1'b0; if_a.data_in = '0; if_a.valid_in = '0;
        if_b.sync_in = 1'b0; if_b.data_in = '0; if_b.valid_in = '0;
        if_c.sync_in = 1'b0; if_c.data_in = '0; if_c.valid_in = '0;
        tick();
        test_reset();
        test_pack0_partial();
        test_pack1();
        test_back_to_back();
        test_sync_mid();
        test_reset_mid_8x16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_nto1_tdm.md
# mux_nto1_tdm

Parametrised N-lane to 1-lane time-division multiplexer with per-lane valid bits and an optional packing mode. It sits on the fast clock side of the lane-combining path. Each frame it captures all LANES input words at once, then emits them one per clock on a single serial byte lane. A lane index and a frame-start marker accompany each word so the downstream demux can realign.

## Interface
- WIDTH, 8, bits per lane word
- LANES, 4, number of input lanes; power of two, ≥2; LW = $clog2(LANES)
- PACK, 0, 0 = fixed slot order; 1 = only valid lanes emitted, compacted to the front of the frame
- clk_4f  input  1  single clock for the block; runs LANES× the lane word rate
- reset  input  1  asynchronous, active-high reset
- sync_in  input  1  frame-alignment pulse; forces a capture and restarts the slot count
- data_in  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- valid_in  input  LANES  valid bit per lane
- data_out  output  WIDTH  serialized word (registered)
- valid_out  output  1  data_out holds a valid lane word (registered)
- lane_out  output  LW  source lane index of data_out (registered)
- frame_start  output  1  high with the first slot of every frame (registered)

## Operation
- Internal state:
  - slot counter cnt, LW bits
  - shadow data register sh_data, LANES*WIDTH bits
  - shadow valid register sh_valid, LANES bits
  - output registers
- Capture condition: cap = (cnt == LANES-1) | sync_in.
  - On cap: sh_data ← data_in, sh_valid ← valid_in, cnt ← 0.
  - Otherwise: cnt ← cnt+1.
- Slot mapping for the current cnt, evaluated on pre-edge values:
  - PACK=0:
    - lane = cnt
    - valid_out ← sh_valid[cnt]
    - data_out ← sh_data[lane] if valid, else 0
    - lane_out ← cnt
  - PACK=1:
    - Let P = popcount(sh_valid).
    - If cnt < P: lane = index of the (cnt+1)-th set bit of sh_valid, scanning from bit 0. valid_out ← 1, data_out ← sh_data[lane], lane_out ← lane.
    - If cnt ≥ P: valid_out ← 0, data_out ← 0, lane_out ← 0.
- frame_start ← (cnt == 0) every edge.
- sync_in mid-frame:
  - Capture occurs at that edge.
  - The slot computed at that edge is still emitted.
  - Remaining slots of the interrupted frame are dropped.
- sync_in when cnt == LANES-1: identical to a normal capture; no extra effect.
- All-invalid frame: LANES slots with valid_out=0 and data_out=0. frame_start still pulses.

## Timing
- Reset (asynchronous, immediate):
  - cnt = LANES-1
  - sh_data = 0, sh_valid = 0
  - data_out = 0, valid_out = 0, lane_out = 0, frame_start = 0
- First clock edge after reset release:
  - Captures data_in (cnt == LANES-1).
  - Outputs slot LANES-1 of the zeroed shadow, so valid_out=0.
- Latency: a frame captured at edge E emits slot j on the outputs after edge E+1+j, for j = 0..LANES-1.
  - frame_start = 1 after edge E+1.
- Throughput: one word per clk_4f. Outputs are continuous with no bubbles between frames when sync_in stays low.
- Input hold requirement: data_in/valid_in only need to be stable at capture edges. Between captures they are don't-care.
- Reset mid-frame: outputs clear immediately. The frame in flight is lost and the cold-start sequence above follows.

## Test plan
- Reset values:
  - Assert reset asynchronously between edges → all outputs 0 immediately.
  - Release with data_in=0xDDCCBBAA, valid_in=4'b1111, sync_in=0 → first post-reset edge outputs valid_out=0.
  - Next 4 edges give data_out AA, BB, CC, DD; lane_out 0..3; frame_start 1,0,0,0.
- PACK=0 partial valid:
  - valid_in=4'b0101 with data 0xDDCCBBAA.
  - Slots give (AA,v1,l0), (00,v0,l1), (CC,v1,l2), (00,v0,l3).
- PACK=1 compaction:
  - valid_in=4'b1010, same data.
  - Slots give (BB,v1,l1), (DD,v1,l3), (00,v0,l0), (00,v0,l0).
- Back-to-back frames:
  - Two frames, 0x44332211 then 0x88776655, all valid, no sync.
  - Output is 11,22,33,44,55,66,77,88 on 8 consecutive edges; frame_start high on the 11 and 55 cycles only.
- sync_in mid-frame:
  - Pulse sync_in in the cycle where cnt=1, with new data 0x0F0E0D0C.
  - Emitted slot 1 of the old frame (BB) is followed directly by 0C, 0D, 0E, 0F.
  - frame_start is high with 0C.
- Reset mid-frame with LANES=8, WIDTH=16:
  - Assert reset during slot 3.
  - Outputs go to 0 immediately.
  - After release, the cold-start sequence repeats; the first valid word is lane 0 of the first captured frame.
